// File: rtl/pwm_pkg.sv
// Shared constants for the PWM sequencer: register map, reset period and
// the IDLE/RUN state type used by pwm_seq_ctrl.
package pwm_pkg;

   localparam logic [2:0] ADDR_PERIOD = 3'd4;
   localparam logic [2:0] ADDR_CTRL   = 3'd5;
   localparam logic [2:0] ADDR_FADE   = 3'd6;

   localparam int unsigned RESET_PERIOD = 100;

   typedef logic [0:0] state_t;

   localparam state_t ST_IDLE = 1'b0;
   localparam state_t ST_RUN  = 1'b1;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: active duty register, registered comparator output and,
// when PWM_SEQ_FADE_EN is defined, the triangle fade stepper.
module pwm_channel
   import pwm_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             commit,
   input  logic [WIDTH-1:0] duty_shadow,
   input  logic [WIDTH-1:0] cnt,
   input  logic             run,
`ifdef PWM_SEQ_FADE_EN
   input  logic             wrap,
   input  logic             fade_en,
   input  logic [WIDTH-1:0] period,
`endif
   output logic             led
);

   logic [WIDTH-1:0] duty_q, duty_d;
   logic             led_q, led_d;
`ifdef PWM_SEQ_FADE_EN
   logic             dir_up_q, dir_up_d;
   logic [WIDTH:0]   limit;
   logic [WIDTH:0]   duty_ext;
   logic [WIDTH:0]   duty_inc;
`endif

   // next active duty (load from shadow or fade step) and comparator output
   always_comb begin
      duty_d = duty_q;
`ifdef PWM_SEQ_FADE_EN
      dir_up_d = dir_up_q;
      limit    = {1'b0, period} + (WIDTH+1)'(1);
      duty_ext = {1'b0, duty_q};
      duty_inc = duty_ext + (WIDTH+1)'(1);
      if (commit) begin
         if (fade_en && wrap) begin
            if (dir_up_q) begin
               if (duty_ext >= limit) begin
                  // period shrank below the current duty: head back down
                  duty_d   = duty_q - WIDTH'(1);
                  dir_up_d = 1'b0;
               end else begin
                  duty_d = duty_inc[WIDTH] ? duty_q : duty_inc[WIDTH-1:0];
                  if (duty_inc >= limit) begin
                     dir_up_d = 1'b0;
                  end
               end
            end else begin
               if (duty_q == '0) begin
                  duty_d   = WIDTH'(1);
                  dir_up_d = 1'b1;
               end else begin
                  duty_d = duty_q - WIDTH'(1);
                  if (duty_q == WIDTH'(1)) begin
                     dir_up_d = 1'b1;
                  end
               end
            end
         end else begin
            duty_d = duty_shadow;
         end
      end
`else
      if (commit) begin
         duty_d = duty_shadow;
      end
`endif
      led_d = run && (cnt < duty_q);
   end

   // channel state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         duty_q   <= '0;
         led_q    <= 1'b0;
`ifdef PWM_SEQ_FADE_EN
         dir_up_q <= 1'b1;
`endif
      end else begin
         duty_q   <= duty_d;
         led_q    <= led_d;
`ifdef PWM_SEQ_FADE_EN
         dir_up_q <= dir_up_d;
`endif
      end
   end

   assign led = led_q;

endmodule

// File: rtl/pwm_seq_ctrl.sv
// Multi-channel PWM sequencer: IDLE/RUN FSM, period counter, shadow
// registers with wrap-synchronous commit and a write handshake that stalls
// on the wrap cycle. Optional fade mode is enabled by PWM_SEQ_FADE_EN.
module pwm_seq_ctrl
   import pwm_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned CHANNELS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic [2:0]          wr_addr,
   input  logic [WIDTH-1:0]    wr_data,
   output logic [CHANNELS-1:0] led,
   output logic                period_end
);

   localparam logic [WIDTH-1:0] PERIOD_RST = WIDTH'(RESET_PERIOD);

   state_t                           state_q, state_d;
   logic [WIDTH-1:0]                 cnt_q, cnt_d;
   logic [WIDTH-1:0]                 period_sh_q, period_sh_d;
   logic [WIDTH-1:0]                 period_act_q, period_act_d;
   logic [CHANNELS-1:0][WIDTH-1:0]   duty_sh_q, duty_sh_d;
`ifdef PWM_SEQ_FADE_EN
   logic [CHANNELS-1:0]              fade_mask_q, fade_mask_d;
`endif

   logic wrap;
   logic accept;
   logic ctrl_wr;
   logic start;
   logic stop;
   logic commit;
   logic led_run;

   // handshake and FSM event decode
   always_comb begin
      wrap     = (state_q == ST_RUN) && (cnt_q == period_act_q);
      wr_ready = !wrap;
      accept   = wr_valid && wr_ready;
      ctrl_wr  = accept && (wr_addr == ADDR_CTRL);
      start    = (state_q == ST_IDLE) && ctrl_wr && wr_data[0];
      stop     = (state_q == ST_RUN) && ctrl_wr && !wr_data[0];
      commit   = start || wrap;
      led_run  = (state_q == ST_RUN) && !stop;
   end

   assign period_end = wrap;

   // next-state: FSM, counter, shadow writes and shadow->active commit
   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = ST_RUN;
      end else if (stop) begin
         state_d = ST_IDLE;
      end

      if ((state_q == ST_RUN) && !stop && !wrap) begin
         cnt_d = cnt_q + WIDTH'(1);
      end else begin
         cnt_d = '0;
      end

      period_sh_d = period_sh_q;
      if (accept && (wr_addr == ADDR_PERIOD)) begin
         period_sh_d = wr_data;
      end
      period_act_d = commit ? period_sh_q : period_act_q;

      duty_sh_d = duty_sh_q;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (accept && (wr_addr == 3'(i))) begin
            duty_sh_d[i] = wr_data;
         end
      end

`ifdef PWM_SEQ_FADE_EN
      fade_mask_d = fade_mask_q;
      if (accept && (wr_addr == ADDR_FADE)) begin
         fade_mask_d = wr_data[CHANNELS-1:0];
      end
`endif
   end

   // control registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         period_sh_q  <= PERIOD_RST;
         period_act_q <= PERIOD_RST;
         duty_sh_q    <= '0;
`ifdef PWM_SEQ_FADE_EN
         fade_mask_q  <= '0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         period_sh_q  <= period_sh_d;
         period_act_q <= period_act_d;
         duty_sh_q    <= duty_sh_d;
`ifdef PWM_SEQ_FADE_EN
         fade_mask_q  <= fade_mask_d;
`endif
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      pwm_channel #(
         .WIDTH (WIDTH)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .commit      (commit),
         .duty_shadow (duty_sh_q[g]),
         .cnt         (cnt_q),
         .run         (led_run),
`ifdef PWM_SEQ_FADE_EN
         .wrap        (wrap),
         .fade_en     (fade_mask_q[g]),
         .period      (period_act_d),
`endif
         .led         (led[g])
      );
   end

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Self-checking bench for pwm_seq_ctrl: per-period high-time model with
// directed and randomized register programming.
module tb_pwm_seq_ctrl;

   localparam int unsigned W  = 8;
   localparam int unsigned CH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_valid;
   logic          wr_ready;
   logic [2:0]    wr_addr;
   logic [W-1:0]  wr_data;
   logic [CH-1:0] led;
   logic          period_end;

   pwm_seq_ctrl #(
      .WIDTH    (W),
      .CHANNELS (CH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .led        (led),
      .period_end (period_end)
   );

   always #5 clk = ~clk;

   int unsigned n_cmp  = 0;
   int unsigned n_fail = 0;

   // per-period observations: one window = the period_end-delimited period
   // shifted by the one-cycle led latency
   int unsigned win_hi [512][CH];
   int unsigned win_len[512];
   int unsigned win_total = 0;
   int unsigned acc[CH];
   int unsigned acc_len = 0;
   bit          pe_prev = 1'b0;
   int unsigned clr_gen = 0;
   int unsigned clr_seen = 0;
   int unsigned pe_count = 0;

   // reference register image (what software has written)
   int unsigned m_period;
   int unsigned m_duty[CH];

   always @(posedge clk) begin
      #2;
      if (clr_gen != clr_seen) begin
         clr_seen = clr_gen;
         for (int i = 0; i < CH; i++) acc[i] = 0;
         acc_len = 0;
      end else begin
         for (int i = 0; i < CH; i++) acc[i] += (led[i] === 1'b1) ? 1 : 0;
         acc_len++;
         if (pe_prev) begin
            if (win_total < 512) begin
               for (int i = 0; i < CH; i++) win_hi[win_total][i] = acc[i];
               win_len[win_total] = acc_len;
            end
            win_total++;
            for (int i = 0; i < CH; i++) acc[i] = 0;
            acc_len = 0;
         end
      end
      pe_prev = (period_end === 1'b1);
      if (period_end === 1'b1) pe_count++;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic timeout_fail(input string tag);
      n_cmp++;
      n_fail++;
      $error("FAIL %s: got timeout expected event", tag);
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // one register write; idx = windows completed once the write is accepted
   task automatic wr(input logic [2:0] a, input logic [W-1:0] d, output int unsigned idx);
      int unsigned k;
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      k = 0;
      while (wr_ready !== 1'b1 && k < 300) begin
         tick(1);
         k++;
      end
      if (k == 300) timeout_fail("wr_ready_wait");
      tick(1);
      wr_valid = 1'b0;
      idx = win_total;
   endtask

   task automatic wait_win(input int unsigned target);
      int unsigned k;
      k = 0;
      while (win_total < target && k < 3000) begin
         tick(1);
         k++;
      end
      if (k == 3000) timeout_fail("window_wait");
   endtask

   function automatic int unsigned exp_hi(input int unsigned d, input int unsigned p);
      return (d > p + 1) ? p + 1 : d;
   endfunction

   task automatic check_win(input int unsigned idx, input string tag);
      check($sformatf("%s_len", tag), win_len[idx], m_period + 1);
      for (int i = 0; i < CH; i++)
         check($sformatf("%s_hi%0d", tag, i), win_hi[idx][i], exp_hi(m_duty[i], m_period));
   endtask

   initial begin
      int unsigned n;
      int unsigned base;
      int unsigned k;
      int unsigned pe0;
      int unsigned p;
      logic [W-1:0] d;

      rst      = 1'b1;
      wr_valid = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      tick(3);
      rst = 1'b0;
      tick(2);
      check("rst_led", led, 0);
      check("rst_pe", period_end, 0);
      check("rst_ready", wr_ready, 1);

      // basic four-channel pattern
      m_period = 99;
      m_duty = '{10, 30, 50, 70};
      wr(3'd4, 8'd99, n);
      for (int i = 0; i < CH; i++) wr(3'(i), W'(m_duty[i]), n);
      wr(3'd5, 8'd1, n);
      clr_gen++;
      base = win_total;
      check("entry_pe", period_end, 0);
      check("entry_ready", wr_ready, 1);
      wait_win(base + 3);
      for (int w = 0; w < 3; w++) check_win(base + w, $sformatf("basic%0d", w));

      // duty change mid-period takes effect only from the next period
      tick($urandom_range(10, 60));
      wr(3'd0, 8'd60, n);
      m_duty[0] = 60;
      wait_win(n + 2);
      check("midchg_old_hi0", win_hi[n][0], 10);
      check_win(n + 1, "midchg_new");

      // write presented on the wrap cycle is stalled one cycle, then taken once
      k = 0;
      while (wr_ready !== 1'b0 && k < 300) begin
         tick(1);
         k++;
      end
      if (k == 300) timeout_fail("wrap_wait");
      wr_valid = 1'b1;
      wr_addr  = 3'd1;
      wr_data  = 8'd45;
      check("wrap_ready", wr_ready, 0);
      check("wrap_pe", period_end, 1);
      tick(1);
      check("after_wrap_ready", wr_ready, 1);
      check("after_wrap_pe", period_end, 0);
      tick(1);
      wr_valid = 1'b0;
      n = win_total;
      m_duty[1] = 45;
      wait_win(n + 2);
      check("wrapwr_old_hi1", win_hi[n][1], 30);
      check_win(n + 1, "wrapwr_new");

      // randomized programming rounds with junk and undefined-address writes
      for (int r = 0; r < 4; r++) begin
         p = $urandom_range(3, 40);
         wr(3'd0, W'($urandom), n);
         wr(3'd7, W'($urandom), n);
`ifndef PWM_SEQ_FADE_EN
         wr(3'd6, W'($urandom), n);
`endif
         wr(3'd4, W'(p), n);
         m_period = p;
         for (int i = 0; i < CH; i++) begin
            if ($urandom_range(0, 1) == 1) d = W'($urandom_range(0, 255));
            else d = W'($urandom_range(0, p + 2));
            wr(3'(i), d, n);
            m_duty[i] = int'(d);
         end
         wait_win(n + 3);
         check_win(n + 1, $sformatf("rnd%0d_a", r));
         check_win(n + 2, $sformatf("rnd%0d_b", r));
      end

      // duty extremes
      m_period = 99;
      wr(3'd4, 8'd99, n);
      wr(3'd0, 8'd0, n);
      wr(3'd1, 8'd255, n);
      m_duty[0] = 0;
      m_duty[1] = 255;
      wait_win(n + 3);
      check_win(n + 1, "ext_a");
      check_win(n + 2, "ext_b");
      check("ext_const_hi1", win_hi[n + 2][1], win_len[n + 2]);

      // disable mid-period, then reset mid-period
      tick($urandom_range(5, 40));
      wr(3'd5, 8'd0, n);
      check("off_led", led, 0);
      pe0 = pe_count;
      tick(150);
      check("off_pe_count", pe_count, pe0);
      check("off_led_late", led, 0);
      wr(3'd5, 8'd1, n);
      tick($urandom_range(20, 60));
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("rst2_led", led, 0);
      check("rst2_pe", period_end, 0);
      check("rst2_ready", wr_ready, 1);
      pe0 = pe_count;
      tick(120);
      check("rst2_pe_count", pe_count, pe0);
      m_period = 100;
      m_duty = '{0, 0, 0, 0};
      wr(3'd5, 8'd1, n);
      clr_gen++;
      base = win_total;
      wait_win(base + 2);
      check_win(base, "rstval_a");
      check_win(base + 1, "rstval_b");
      wr(3'd5, 8'd0, n);

`ifdef PWM_SEQ_FADE_EN
      // triangle fade on channel 0 with period 3
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(1);
      wr(3'd4, 8'd3, n);
      wr(3'd6, 8'd1, n);
      wr(3'd5, 8'd1, n);
      clr_gen++;
      base = win_total;
      wait_win(base + 10);
      for (int w = 0; w < 10; w++) begin
         int unsigned t;
         t = w % 8;
         check($sformatf("fade%0d_hi0", w), win_hi[base + w][0], (t <= 4) ? t : 8 - t);
         check($sformatf("fade%0d_len", w), win_len[base + w], 4);
         check($sformatf("fade%0d_hi1", w), win_hi[base + w][1], 0);
      end
      wr(3'd5, 8'd0, n);
`endif

      tick(5);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pwm_seq_ctrl.md
PWM_SEQ_CTRL -- requirements
Module: pwm_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter/duty/period width.
REQ-002 SHALL have parameter CHANNELS, default 4, number of PWM outputs.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_valid  input  1  register write request.
REQ-006 SHALL have port wr_ready  output  1  write accepted when wr_valid && wr_ready.
REQ-007 SHALL have port wr_addr  input  3  0..CHANNELS-1 duty, 4 period, 5 control (bit0 enable), 6 fade mask.
REQ-008 SHALL have port wr_data  input  WIDTH  write data.
REQ-009 SHALL have port led  output  CHANNELS  PWM outputs.
REQ-010 SHALL have port period_end  output  1  one-cycle pulse on the counter wrap cycle.

Function
REQ-011 SHALL implement FSM IDLE/RUN; IDLE: counter held 0, led all 0, period_end 0.
REQ-012 SHALL go IDLE->RUN on an accepted control write with bit0=1; the first RUN cycle has counter=0 and shadow values already committed.
REQ-013 SHALL go RUN->IDLE on an accepted control write with bit0=0; led all 0 from the next cycle.
REQ-014 SHALL count 0..period in RUN, wrapping to 0, giving period+1 cycles per PWM period; period=0 holds counter at 0.
REQ-015 SHALL drive led[i]=1 in RUN iff counter < duty_active[i] (registered output, one-cycle latency from counter); duty 0 -> constant low, duty > period -> constant high.
REQ-016 SHALL store duty/period writes in shadow registers one cycle after acceptance; active values change only at commit.
REQ-017 SHALL commit shadow->active at the wrap cycle (RUN, counter==period) and on IDLE->RUN entry; never mid-period.
REQ-018 SHALL deassert wr_ready exactly on the wrap cycle in RUN, so writes never coincide with a commit; wr_ready=1 otherwise.
REQ-019 SHALL accept writes to undefined addresses (7, or CHANNELS..3) and discard them.
REQ-020 SHALL assert period_end for one cycle on each wrap cycle in RUN only.
REQ-021 SHALL treat a later write to the same address before commit as overwriting the earlier one (last write wins).

Reset
REQ-022 SHALL on rst: state IDLE, counter 0, all shadow/active duty 0, period shadow/active 100, fade mask 0, fade directions up, led 0, period_end 0, wr_ready 1.
REQ-023 SHALL let rst mid-period override all activity in the same edge, with no partial commit.

Configuration
REQ-024 SHALL support macro PWM_SEQ_FADE_EN; when defined, each channel with fade-mask bit set steps duty_active by +-1 at every commit instead of loading shadow, reversing direction upon reaching 0 or period+1.
REQ-025 SHALL, when PWM_SEQ_FADE_EN is defined, reload a channel from its shadow on the first commit after its mask bit clears.
REQ-026 SHALL, without PWM_SEQ_FADE_EN, accept and discard writes to address 6; no fade logic.

Structure
REQ-027 SHALL place address constants (ADDR_PERIOD=4, ADDR_CTRL=5, ADDR_FADE=6), reset period (100) and the IDLE/RUN state typedef in shared package pwm_pkg.
REQ-028 SHALL instantiate one sub-module pwm_channel per channel (active duty register, comparator, fade step logic); pwm_seq_ctrl owns FSM, counter, shadows and handshake.

Verification
REQ-029 SHALL cover: reset, period=99, duties 10/30/50/70, enable -> led[0..3] high 10/30/50/70 of every 100 cycles, period_end every 100 cycles.
REQ-030 SHALL cover: duty0 changed 10->60 mid-period -> led[0] keeps 10-cycle pulse until wrap, 60-cycle pulse from next period.
REQ-031 SHALL cover: wr_valid held on wrap cycle -> wr_ready 0 that cycle, write accepted the next cycle, no lost/duplicated write.
REQ-032 SHALL cover: duty0=0 and duty1=255 with period 99 -> led[0] never high, led[1] constantly high.
REQ-033 SHALL cover: control write 0 mid-period then rst mid-period -> led 0 next cycle, period_end never pulses, all registers at reset values.
REQ-034 SHALL cover (PWM_SEQ_FADE_EN): period=3, fade mask 1 -> led[0] high-time sequence 0,1,2,3,4,3,2,1,0,1 over successive periods.
